// File: rtl/grid_pkg.sv
// Shared grid constants and arbiter state encoding.
// Used by the write arbiter, the VGA renderer and the game FSMs.
package grid_pkg;

    localparam int GRID_ROWS  = 8;
    localparam int GRID_COLS  = 8;
    localparam int GRID_ROW_W = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_ARB   = 2'd2,
        S_WRITE = 2'd3
    } grid_state_e;

    function automatic logic [1:0] gnt_onehot(input logic winner);
        return winner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/grid_write_arbiter_if.sv
// Row-write request/grant bus between the game FSMs and the grid write arbiter,
// plus the committed row-write port towards grid storage.
interface grid_write_arbiter_if #(
    parameter int COLS  = 8,
    parameter int ROW_W = 3
) ();

    logic [1:0]       req;
    logic [ROW_W-1:0] req_row0;
    logic [COLS-1:0]  req_data0;
    logic [ROW_W-1:0] req_row1;
    logic [COLS-1:0]  req_data1;
    logic [1:0]       gnt;
    logic             wr_strobe;
    logic [ROW_W-1:0] wr_row;
    logic [COLS-1:0]  wr_data;

    modport master (
        output req, req_row0, req_data0, req_row1, req_data1,
        input  gnt, wr_strobe, wr_row, wr_data
    );

    modport slave (
        input  req, req_row0, req_data0, req_row1, req_data1,
        output gnt, wr_strobe, wr_row, wr_data
    );

endinterface

// File: rtl/grid_write_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin picker: a lone request wins outright,
// a tie goes to the requester that was not granted last.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid  = |req;
        winner = 1'b0;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_gnt;
            default: winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/grid_write_arbiter.sv
// Owns the single row-write port of the display grid: full clear sweep on each start edge,
// round-robin row writes from two requesters. Define GRID_VBLANK_SYNC_EN to confine writes to vblank.
module grid_write_arbiter
    import grid_pkg::*;
#(
    parameter int ROWS  = GRID_ROWS,
    parameter int COLS  = GRID_COLS,
    parameter int ROW_W = GRID_ROW_W
) (
    input  logic                board_clk,
    input  logic                reset,
    input  logic                start,
    input  logic                vblank,
    grid_write_arbiter_if.slave bus,
    output logic                busy,
    output logic                clear_done
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    grid_state_e      state, state_nx;
    logic [ROW_W-1:0] clr_cnt, clr_cnt_nx;
    logic             start_q, start_edge;
    logic             last_gnt, win_q, win_nx;
    logic             arb_valid, arb_winner, window_open;
    logic             strobe_nx, busy_nx, done_nx;
    logic [1:0]       gnt_nx;
    logic [ROW_W-1:0] row_nx;
    logic [COLS-1:0]  data_nx;

    assign start_edge = start & ~start_q;

`ifdef GRID_VBLANK_SYNC_EN
    assign window_open = vblank;
`else
    logic unused_vblank;
    assign window_open   = 1'b1;
    assign unused_vblank = vblank;
`endif

    rr_arbiter2 u_rr (
        .req      (bus.req),
        .last_gnt (last_gnt),
        .valid    (arb_valid),
        .winner   (arb_winner)
    );

    // Outputs are registered: everything below computes the values for the coming cycle.
    always_comb begin
        state_nx   = state;
        clr_cnt_nx = clr_cnt;
        win_nx     = win_q;
        done_nx    = 1'b0;
        strobe_nx  = 1'b0;
        gnt_nx     = 2'b00;
        row_nx     = '0;
        data_nx    = '0;

        case (state)
            S_IDLE: begin
                if (start_edge) begin
                    state_nx   = S_CLEAR;
                    clr_cnt_nx = '0;
                end
            end
            S_CLEAR: begin
                // The counter only advances on cycles that actually wrote a row.
                if (bus.wr_strobe) begin
                    if (clr_cnt == LAST_ROW) begin
                        state_nx   = S_ARB;
                        clr_cnt_nx = '0;
                        done_nx    = 1'b1;
                    end else begin
                        clr_cnt_nx = clr_cnt + 1'b1;
                    end
                end
            end
            S_ARB: begin
                if (start_edge) begin
                    state_nx   = S_CLEAR;
                    clr_cnt_nx = '0;
                end else if (arb_valid && window_open) begin
                    state_nx = S_WRITE;
                    win_nx   = arb_winner;
                end
            end
            S_WRITE: state_nx = S_ARB;
            default: state_nx = S_IDLE;
        endcase

        case (state_nx)
            S_CLEAR: begin
                strobe_nx = window_open;
                row_nx    = clr_cnt_nx;
            end
            S_WRITE: begin
                strobe_nx = 1'b1;
                gnt_nx    = gnt_onehot(win_nx);
                row_nx    = win_nx ? bus.req_row1  : bus.req_row0;
                data_nx   = win_nx ? bus.req_data1 : bus.req_data0;
            end
            default: ;
        endcase

        busy_nx = (state_nx == S_CLEAR) || (state_nx == S_WRITE);
    end

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            clr_cnt       <= '0;
            start_q       <= 1'b0;
            last_gnt      <= 1'b1;
            win_q         <= 1'b0;
            bus.wr_strobe <= 1'b0;
            bus.gnt       <= 2'b00;
            bus.wr_row    <= '0;
            bus.wr_data   <= '0;
            busy          <= 1'b0;
            clear_done    <= 1'b0;
        end else begin
            state         <= state_nx;
            clr_cnt       <= clr_cnt_nx;
            start_q       <= start;
            win_q         <= win_nx;
            if (state == S_WRITE)
                last_gnt  <= win_q;
            bus.wr_strobe <= strobe_nx;
            bus.gnt       <= gnt_nx;
            bus.wr_row    <= row_nx;
            bus.wr_data   <= data_nx;
            busy          <= busy_nx;
            clear_done    <= done_nx;
        end
    end

endmodule

// File: tb/tb_grid_write_arbiter.sv
// Self-checking bench for grid_write_arbiter: directed scenarios plus a randomized
// two-requester run checked against a rule-level arbitration model.
`timescale 1ns/1ps
module tb_grid_write_arbiter;
    import grid_pkg::*;

    localparam int ROWS  = GRID_ROWS;
    localparam int COLS  = GRID_COLS;
    localparam int ROW_W = GRID_ROW_W;
    localparam int OW    = ROW_W + COLS + 5;

    logic board_clk = 1'b0;
    logic reset, start, vblank;
    logic busy, clear_done;

    int n_tests = 0;
    int n_fail  = 0;

    grid_write_arbiter_if #(.COLS(COLS), .ROW_W(ROW_W)) bus ();

    grid_write_arbiter #(.ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W)) dut (
        .board_clk  (board_clk),
        .reset      (reset),
        .start      (start),
        .vblank     (vblank),
        .bus        (bus),
        .busy       (busy),
        .clear_done (clear_done)
    );

    always #5 board_clk = ~board_clk;

    function automatic logic [OW-1:0] outs();
        return {bus.wr_strobe, bus.gnt, bus.wr_row, bus.wr_data, busy, clear_done};
    endfunction

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; vblank = 1'b1;
        bus.req = 2'b00; bus.req_row0 = '0; bus.req_data0 = '0;
        bus.req_row1 = '0; bus.req_data1 = '0;
        repeat (2) @(negedge board_clk);
        n_tests++;
        if (outs() !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs());
        end
        reset = 1'b0;
        bus.req = 2'b01; bus.req_row0 = 3'd5; bus.req_data0 = 8'h77;
        for (int i = 0; i < 4; i++) begin
            @(negedge board_clk);
            n_tests++;
            if ({bus.wr_strobe, bus.gnt, busy} !== 4'b0000) begin
                n_fail++; $display("FAIL idle_ignores_req: got %b expected 0000", {bus.wr_strobe, bus.gnt, busy});
            end
        end
        bus.req = 2'b00;
    endtask

    // Called just after a negedge with start low in the previous cycle; checks rows and clear_done.
    task automatic run_sweep();
        logic [OW-1:0] exp;
        start = 1'b1;
        for (int k = 0; k < ROWS; k++) begin
            @(negedge board_clk);
            exp = {1'b1, 2'b00, ROW_W'(k), {COLS{1'b0}}, 1'b1, 1'b0};
            n_tests++;
            if (outs() !== exp) begin
                n_fail++; $display("FAIL sweep_row%0d: got %h expected %h", k, outs(), exp);
            end
        end
        @(negedge board_clk);
        n_tests++;
        if ({bus.wr_strobe, bus.gnt, busy, clear_done} !== 5'b00001) begin
            n_fail++; $display("FAIL clear_done_pulse: got %b expected 00001", {bus.wr_strobe, bus.gnt, busy, clear_done});
        end
    endtask

    task automatic test_clear();
        run_sweep();
        @(negedge board_clk);
        n_tests++;
        if ({bus.wr_strobe, bus.gnt, busy, clear_done} !== 5'b00000) begin
            n_fail++; $display("FAIL after_clear_quiet: got %b expected 00000", {bus.wr_strobe, bus.gnt, busy, clear_done});
        end
    endtask

    task automatic test_alternate();
        logic [1:0] eg;
        bus.req = 2'b11;
        bus.req_row0 = 3'd1; bus.req_data0 = 8'h0F;
        bus.req_row1 = 3'd6; bus.req_data1 = 8'hF0;
        for (int g = 0; g < 6; g++) begin
            @(negedge board_clk);
            if (g == 4) bus.req = 2'b00;
            n_tests++;
            if (g % 2 == 0 && g < 5) begin
                eg = ((g / 2) % 2 == 0) ? 2'b01 : 2'b10;
                if ({bus.wr_strobe, bus.gnt, busy, bus.wr_row, bus.wr_data} !==
                    {1'b1, eg, 1'b1, (eg == 2'b01) ? {3'd1, 8'h0F} : {3'd6, 8'hF0}}) begin
                    n_fail++; $display("FAIL alternate_grant%0d: got gnt=%b row=%0d data=%h strobe=%b expected gnt=%b",
                                       g, bus.gnt, bus.wr_row, bus.wr_data, bus.wr_strobe, eg);
                end
            end else if ({bus.wr_strobe, bus.gnt, busy} !== 4'b0000) begin
                n_fail++; $display("FAIL alternate_gap%0d: got %b expected 0000", g, {bus.wr_strobe, bus.gnt, busy});
            end
        end
    endtask

    task automatic test_single();
        bus.req = 2'b01; bus.req_row0 = 3'd3; bus.req_data0 = 8'hA5;
        @(negedge board_clk);
        n_tests++;
        if ({bus.wr_strobe, bus.gnt, bus.wr_row, bus.wr_data, busy} !== {1'b1, 2'b01, 3'd3, 8'hA5, 1'b1}) begin
            n_fail++; $display("FAIL single_write: got strobe=%b gnt=%b row=%0d data=%h expected 1 01 3 a5",
                               bus.wr_strobe, bus.gnt, bus.wr_row, bus.wr_data);
        end
        bus.req = 2'b00; bus.req_data0 = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge board_clk);
            n_tests++;
            if ({bus.wr_strobe, bus.gnt} !== 3'b000) begin
                n_fail++; $display("FAIL single_no_repeat: got %b expected 000", {bus.wr_strobe, bus.gnt});
            end
        end
    endtask

    task automatic test_start_priority();
        start = 1'b0;
        @(negedge board_clk);
        bus.req = 2'b10; bus.req_row1 = 3'd2; bus.req_data1 = 8'h3C;
        run_sweep();
        @(negedge board_clk);
        n_tests++;
        if ({bus.wr_strobe, bus.gnt, bus.wr_row, bus.wr_data} !== {1'b1, 2'b10, 3'd2, 8'h3C}) begin
            n_fail++; $display("FAIL start_priority_grant: got strobe=%b gnt=%b row=%0d data=%h expected 1 10 2 3c",
                               bus.wr_strobe, bus.gnt, bus.wr_row, bus.wr_data);
        end
        bus.req = 2'b00;
        @(negedge board_clk);
    endtask

    task automatic test_reset_mid_sweep();
        start = 1'b0;
        @(negedge board_clk);
        start = 1'b1;
        repeat (5) @(negedge board_clk);
        n_tests++;
        if ({bus.wr_strobe, bus.wr_row} !== {1'b1, 3'd4}) begin
            n_fail++; $display("FAIL midsweep_row4: got strobe=%b row=%0d expected 1 4", bus.wr_strobe, bus.wr_row);
        end
        reset = 1'b1; start = 1'b0;
        #1;
        n_tests++;
        if (outs() !== '0) begin
            n_fail++; $display("FAIL midsweep_reset_outputs: got %h expected 0", outs());
        end
        @(negedge board_clk);
        reset = 1'b0;
        bus.req = 2'b01; bus.req_row0 = 3'd7; bus.req_data0 = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge board_clk);
            n_tests++;
            if ({bus.wr_strobe, bus.gnt, busy} !== 4'b0000) begin
                n_fail++; $display("FAIL post_reset_no_grant: got %b expected 0000", {bus.wr_strobe, bus.gnt, busy});
            end
        end
        bus.req = 2'b00;
        test_clear();
    endtask

    task automatic test_vblank();
        bit found = 1'b0;
        vblank = 1'b0;
        bus.req = 2'b10; bus.req_row1 = 3'd4; bus.req_data1 = 8'hC3;
`ifdef GRID_VBLANK_SYNC_EN
        for (int i = 0; i < 3; i++) begin
            @(negedge board_clk);
            n_tests++;
            if ({bus.wr_strobe, bus.gnt} !== 3'b000) begin
                n_fail++; $display("FAIL vblank_hold: got %b expected 000", {bus.wr_strobe, bus.gnt});
            end
        end
        vblank = 1'b1;
        for (int i = 0; i < 2 && !found; i++) begin
`else
        for (int i = 0; i < 1 && !found; i++) begin
`endif
            @(negedge board_clk);
            if (bus.wr_strobe === 1'b1) found = 1'b1;
        end
        n_tests++;
        if (!found || {bus.gnt, bus.wr_row, bus.wr_data} !== {2'b10, 3'd4, 8'hC3}) begin
            n_fail++; $display("FAIL vblank_grant: got found=%0d gnt=%b row=%0d data=%h expected 1 10 4 c3",
                               found, bus.gnt, bus.wr_row, bus.wr_data);
        end
        bus.req = 2'b00; vblank = 1'b1;
        @(negedge board_clk);
    endtask

    task automatic test_random();
        logic [1:0]       pend;
        logic [ROW_W-1:0] prow [2];
        logic [COLS-1:0]  pdata[2];
        bit               exp_write;
        int               exp_win, m_last;
        logic [ROW_W-1:0] exp_row;
        logic [COLS-1:0]  exp_data;
        logic [4:0]       exp_ctrl;

        test_reset();
        test_clear();
        pend = 2'b00; exp_write = 1'b0; exp_win = 0; m_last = 1;
        exp_row = '0; exp_data = '0;
        prow[0] = '0; prow[1] = '0; pdata[0] = '0; pdata[1] = '0;

        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge board_clk);
            exp_ctrl = {exp_write, exp_write ? ((exp_win == 1) ? 2'b10 : 2'b01) : 2'b00, exp_write, 1'b0};
            n_tests++;
            if ({bus.wr_strobe, bus.gnt, busy, clear_done} !== exp_ctrl) begin
                n_fail++; $display("FAIL rnd_ctrl cyc %0d: got %b expected %b", cyc,
                                   {bus.wr_strobe, bus.gnt, busy, clear_done}, exp_ctrl);
            end
            if (exp_write) begin
                n_tests++;
                if ({bus.wr_row, bus.wr_data} !== {exp_row, exp_data}) begin
                    n_fail++; $display("FAIL rnd_data cyc %0d: got row=%0d data=%h expected row=%0d data=%h",
                                       cyc, bus.wr_row, bus.wr_data, exp_row, exp_data);
                end
                pend[exp_win] = 1'b0;
                m_last = exp_win;
            end
            for (int r = 0; r < 2; r++) begin
                if (!pend[r]) begin
                    prow[r]  = ROW_W'($urandom);
                    pdata[r] = COLS'($urandom);
                    if ($urandom_range(2) == 0) pend[r] = 1'b1;
                end
            end
            bus.req = pend;
            bus.req_row0 = prow[0]; bus.req_data0 = pdata[0];
            bus.req_row1 = prow[1]; bus.req_data1 = pdata[1];

            // Arbitration happens in every cycle that is not itself a write cycle.
            if (!exp_write && pend != 2'b00) begin
                exp_write = 1'b1;
                if (pend[0] && pend[1]) exp_win = (m_last == 0) ? 1 : 0;
                else                    exp_win = pend[1] ? 1 : 0;
                exp_row  = prow[exp_win];
                exp_data = pdata[exp_win];
            end else begin
                exp_write = 1'b0;
            end
        end
        bus.req = 2'b00;
        @(negedge board_clk);
    endtask

    initial begin
        test_reset();
        test_clear();
        test_alternate();
        test_single();
        test_start_priority();
        test_reset_mid_sweep();
        test_vblank();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
